// File: rtl/sf_push_arbiter.sv
// Round-robin arbiter in front of a single FIFO push port. Each grant is a
// burst of up to MaxBurst accepted pushes, stalled by fFULL.

module sf_push_lane #(
  parameter int Width = 32
) (
  input  logic             sel,
  input  logic             req,
  input  logic             full,
  input  logic [Width-1:0] d,
  output logic             ack,
  output logic [Width-1:0] q
);
  assign ack = sel & req & ~full;
  assign q   = sel ? d : '0;
endmodule

module sf_push_arbiter #(
  parameter int Width    = 32,
  parameter int NumReq   = 4,
  parameter int MaxBurst = 4,
  localparam int Iw = $clog2(NumReq),
  localparam int Cw = $clog2(MaxBurst + 1)
) (
  input  logic                    fCLK,
  input  logic                    fRSTn,
  input  logic                    en_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] data_i,
  output logic [NumReq-1:0]       ack_o,
  output logic [NumReq-1:0]       gnt_o,
  output logic                    busy_o,
  output logic                    fPUSH,
  output logic [Width-1:0]        fD,
  input  logic                    fFULL
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nxt;
  logic [Iw-1:0] owner, owner_nxt, last, last_nxt, win;
  logic [Cw-1:0] cnt, cnt_nxt;

  logic [NumReq-1:0][Width-1:0] lane_d, lane_q;
  logic [2*NumReq-1:0]          rot_w;
  logic [NumReq-1:0]            rot;

  assign lane_d = data_i;
  assign busy_o = (state == BURST);

  always_comb begin
    gnt_o = '0;
    if (state == BURST) gnt_o[owner] = 1'b1;
  end

  // Per-requester ack and data gating; only the owner lane is ever non-zero.
  for (genvar k = 0; k < NumReq; k++) begin : g_lane
    sf_push_lane #(.Width(Width)) u_lane (
      .sel  (gnt_o[k]),
      .req  (req_i[k]),
      .full (fFULL),
      .d    (lane_d[k]),
      .ack  (ack_o[k]),
      .q    (lane_q[k])
    );
  end

  assign fPUSH = |ack_o;

  always_comb begin
    fD = '0;
    for (int k = 0; k < NumReq; k++) fD = fD | lane_q[k];
  end

  // Rotate so bit j is requester (last+1+j) mod NumReq; lowest set bit wins.
  assign rot_w = {req_i, req_i} >> (32'(last) + 32'd1);
  assign rot   = rot_w[NumReq-1:0];

  always_comb begin
    win = '0;
    for (int j = NumReq - 1; j >= 0; j--)
      if (rot[j]) win = Iw'((int'(last) + 1 + j) % NumReq);
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (en_i && |req_i) begin
          owner_nxt = win;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (!req_i[owner]) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else if (fPUSH) begin
          cnt_nxt = cnt + Cw'(1);
          if (cnt == Cw'(MaxBurst - 1)) begin
            state_nxt = IDLE;
            last_nxt  = owner;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fCLK or negedge fRSTn) begin
    if (!fRSTn) begin
      state <= IDLE;
      owner <= '0;
      last  <= Iw'(NumReq - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  a_gnt_onehot: assert property (@(posedge fCLK) disable iff (!fRSTn) $onehot0(gnt_o));
  a_ack_subset: assert property (@(posedge fCLK) disable iff (!fRSTn) (ack_o & ~gnt_o) == '0);
  a_push_ack:   assert property (@(posedge fCLK) disable iff (!fRSTn) fPUSH == (|ack_o));

endmodule

// File: doc/sf_push_arbiter.md
Name: sf_push_arbiter

Overview:
- Round-robin arbiter that shares the single push port of one simple FIFO between NumReq producers.
- Each grant is a burst of up to MaxBurst accepted pushes. Back-pressure comes from the FIFO's fFULL flag.
- Sits directly in front of the FIFO. Drives fPUSH and fD. Returns a per-requester ack to each producer.

Parameters:
- Width, 32, data word width; must match the FIFO Width.
- NumReq, 4, number of requesters; 2..16.
- MaxBurst, 4, maximum accepted pushes per grant; >=1.
- Iw (localparam), $clog2(NumReq), owner index width.
- Cw (localparam), $clog2(MaxBurst+1), beat counter width.

Ports:
- fCLK  in  1  clock; all state on rising edge.
- fRSTn  in  1  reset, asynchronous, active-low.
- en_i  in  1  arbitration enable; low blocks new grants only.
- req_i  in  NumReq  per-requester push request; level, held while data is pending.
- data_i  in  NumReq*Width  packed request data; requester k uses bits [k*Width +: Width].
- ack_o  out  NumReq  requester k's word is accepted this cycle.
- gnt_o  out  NumReq  one-hot current owner; registered.
- busy_o  out  1  high while in BURST.
- fPUSH  out  1  push to FIFO.
- fD  out  Width  push data to FIFO.
- fFULL  in  1  FIFO full flag.

Behaviour:
- State machine: IDLE, BURST. State is held in registers: state, owner[Iw], last[Iw], cnt[Cw].
- Reset values:
  - state=IDLE, owner=0, cnt=0, last=NumReq-1, so requester 0 wins first.
  - Outputs: gnt_o=0, busy_o=0, ack_o=0, fPUSH=0, fD=0.
- IDLE, with en_i=1 and |req_i:
  - Winner is the first k with req_i[k]=1, scanning (last+1) mod NumReq upward with wrap.
  - Next cycle: owner<=k, cnt<=0, state<=BURST.
  - No push occurs in the arbitration cycle, giving 1 cycle of grant latency.
- IDLE otherwise: hold state. fPUSH=0.
- In BURST, combinational outputs:
  - fPUSH = req_i[owner] & ~fFULL.
  - ack_o[owner] = fPUSH; all other ack bits are 0.
  - fD = data_i slice of owner in BURST, 0 in IDLE.
  - gnt_o = one-hot(owner) and busy_o=1 while state=BURST, else 0.
- BURST counting: each cycle with fPUSH=1 sets cnt<=cnt+1.
- BURST exit to IDLE, with last<=owner, on either condition:
  - (a) fPUSH=1 and cnt==MaxBurst-1. The final beat is accepted this same cycle.
  - (b) req_i[owner]=0. No push occurs that cycle.
- fFULL=1 in BURST: no push, no ack, cnt holds, state holds. The grant is not released while full and req is held.
- en_i=0 during BURST: the burst continues to normal exit. The arbiter then stays in IDLE until en_i=1.
- Requester re-arbitration: a requester whose burst ended goes to lowest priority. Re-grant happens only when no other requester is requesting.
- MaxBurst=1: every grant carries exactly one accepted beat.
- Throughput: at most MaxBurst words per MaxBurst+1 cycles per grant, because of the IDLE gap.
- Requester contract: data_i of a requester must be stable while its req is high and not yet acked. The arbiter does not register data.
- fRSTn low mid-burst: immediate return to reset values. The partial burst is abandoned; words already acked stay in the FIFO.
- Simulation only: assertions check that gnt_o is one-hot-or-zero, that ack_o is a subset of gnt_o, and that fPUSH equals |ack_o.

Test Plan:
- Single requester, MaxBurst=4: req_i=0001 held 6 cycles, fFULL=0.
  - gnt_o=0001 from cycle 2; acks in cycles 2-5 (4 beats).
  - IDLE in cycle 6, re-grant in cycle 7; fD matches data_i[31:0] on each ack.
- All requesters, req_i=1111 held: grants in order 0,1,2,3,0.
  - Each grant yields 4 acks, separated by 1 idle cycle.
- Early drop: req_i[2] alone is granted, then dropped after 2 acks.
  - cnt stops at 2; IDLE the next cycle; last=2.
  - With req_i=0101 next, grant goes to 0 (scan 3,0).
- Back-pressure: fFULL=1 for 3 cycles mid-burst after 1 ack.
  - No fPUSH or ack for those 3 cycles; gnt_o holds.
  - Remaining 3 acks follow once fFULL=0.
- en_i: en_i=0 with req_i=0010 gives gnt_o=0 indefinitely.
  - Set en_i=1 → grant next cycle.
  - Drop en_i mid-burst → burst completes all 4 beats.
- Reset mid-burst: assert fRSTn=0 at beat 2 of owner 1.
  - All outputs are 0 immediately.
  - After release with req_i=1111, first grant goes to requester 0.
